fpu_poly_evaluator: RTL
=======================

FPU_POLY_EVALUATOR -- requirements
Module: fpu_poly_evaluator

Interface
REQ-001 SHALL have parameter NONE; coefficient-count table fixed internally: poly 0 (F2XM1) = 6 coefficients, poly 1 (LOG2) = 8 coefficients.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous reset, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request, sampled only in IDLE.
REQ-005 SHALL have port poly_select  input  4  polynomial id, captured on accepted start.
REQ-006 SHALL have port x_in  input  80  FP80 argument, captured on accepted start.
REQ-007 SHALL have port rom_poly_select  output  4  to coefficient ROM; equals the captured poly_select.
REQ-008 SHALL have port rom_coeff_index  output  4  to coefficient ROM.
REQ-009 SHALL have port rom_coefficient  input  80  combinational ROM data for the current index.
REQ-010 SHALL have port arith_req  output  1  one-cycle operation request.
REQ-011 SHALL have port arith_op  output  1  0 = multiply, 1 = add.
REQ-012 SHALL have ports arith_a, arith_b  output  80  operands, held stable from arith_req until arith_done.
REQ-013 SHALL have port arith_done  input  1  one-cycle completion pulse.
REQ-014 SHALL have ports arith_result  input  80 (valid with arith_done) and arith_invalid  input  1 (invalid-operation flag, valid with arith_done).
REQ-015 SHALL have ports busy  output  1; done  output  1 (one-cycle pulse); error  output  1; result  output  80.

Function
REQ-016 SHALL evaluate by Horner: acc = c[N-1]; for i = N-2 downto 0: acc = acc*x, acc = acc + c[i]; finally acc = acc*x.
REQ-017 SHALL issue exactly N multiplies and N-1 adds per run (F2XM1: 6 mul/5 add; LOG2: 8 mul/7 add), strictly alternating mul/add, ending with mul.
REQ-018 SHALL use FSM states IDLE, LOAD, MUL_REQ, MUL_WAIT, ADD_REQ, ADD_WAIT, FIN_REQ, FIN_WAIT, DONE.
REQ-019 SHALL transition IDLE->LOAD on start (busy=1 from next cycle); LOAD latches acc = rom_coefficient at index N-1, sets index N-2, goes to MUL_REQ.
REQ-020 SHALL in MUL_REQ pulse arith_req with op 0, a=acc, b=x; in ADD_REQ pulse op 1, a=acc, b=rom_coefficient at current index; FIN_REQ as MUL_REQ.
REQ-021 SHALL remain in *_WAIT until arith_done; on it latch acc=arith_result; MUL_WAIT->ADD_REQ; ADD_WAIT->MUL_REQ with index-1 if index>0, else FIN_REQ; FIN_WAIT->DONE.
REQ-022 SHALL in DONE pulse done=1 for one cycle with result=acc, then return to IDLE with busy=0; latency = 2 cycles + sum of arith latencies + 2N-1 request cycles + 1.
REQ-023 SHALL hold result and error stable from done until the next accepted start.
REQ-024 SHALL ignore start while busy.
REQ-025 SHALL, for poly_select > 1, go IDLE->DONE directly: done pulse two cycles after start, error=1, result=0, no arith_req.
REQ-026 SHALL, on arith_done with arith_invalid=1, abort to DONE: error=1, result=80'h7FFF_C000000000000000 (default QNaN).
REQ-027 SHALL ignore arith_done outside *_WAIT states.

Reset
REQ-028 SHALL on reset_n=0 at a clock edge force IDLE, busy=0, done=0, error=0, arith_req=0, result=0, acc=0, index=0, regardless of state; an in-flight arith_done after reset is ignored.

Structure
REQ-029 SHALL place poly ids (F2XM1=0, LOG2=1), coefficient counts, FSM state encoding and the default QNaN constant in the shared FPU package.
REQ-030 SHALL be a single module; the coefficient ROM and arithmetic unit are instantiated outside it, with no sub-module inside.

Verification
REQ-031 SHALL cover: F2XM1, x=0, arith model 3-cycle latency -> index sequence 5,4,3,2,1,0, 6 mul/5 add alternating, result +0, error=0.
REQ-032 SHALL cover: LOG2, x=1.0 (3FFF_8000000000000000) -> 8 mul/7 add, index order 7..0, result equals model Horner sum, single done pulse.
REQ-033 SHALL cover: poly_select=2 -> done two cycles after start, error=1, result 0, arith_req never asserted.
REQ-034 SHALL cover: second start asserted mid-run -> ignored; only one done pulse; op count unchanged.
REQ-035 SHALL cover: arith_invalid=1 on third arith_done -> done next cycle, error=1, result 7FFF_C000000000000000.
REQ-036 SHALL cover: reset_n low during ADD_WAIT, late arith_done after release -> outputs at reset values, FSM stays IDLE, new start runs normally.

Source files
------------

// File: rtl/fpu_poly_evaluator_pkg.sv
// Shared FPU definitions for the polynomial evaluator: polynomial ids,
// coefficient counts, sequencer state encoding and the default quiet NaN.
package fpu_poly_evaluator_pkg;

    localparam int FP_W = 80;

    localparam logic [3:0] POLY_F2XM1 = 4'd0;
    localparam logic [3:0] POLY_LOG2  = 4'd1;

    localparam logic [3:0] F2XM1_NCOEF = 4'd6;
    localparam logic [3:0] LOG2_NCOEF  = 4'd8;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_ADD = 1'b1;

    localparam logic [FP_W-1:0] FP80_DEFAULT_QNAN = 80'h7FFF_C000000000000000;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        MUL_REQ,
        MUL_WAIT,
        ADD_REQ,
        ADD_WAIT,
        FIN_REQ,
        FIN_WAIT,
        DONE
    } poly_state_t;

    function automatic logic [3:0] coeff_count(input logic [3:0] sel);
        return (sel == POLY_LOG2) ? LOG2_NCOEF : F2XM1_NCOEF;
    endfunction

endpackage

// File: rtl/fpu_poly_evaluator.sv
// Horner-scheme polynomial sequencer: walks an external coefficient ROM and
// drives an external FP80 multiply/add unit, one operation at a time.
module fpu_poly_evaluator
    import fpu_poly_evaluator_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  poly_select,
    input  logic [79:0] x_in,
    output logic [3:0]  rom_poly_select,
    output logic [3:0]  rom_coeff_index,
    input  logic [79:0] rom_coefficient,
    output logic        arith_req,
    output logic        arith_op,
    output logic [79:0] arith_a,
    output logic [79:0] arith_b,
    input  logic        arith_done,
    input  logic [79:0] arith_result,
    input  logic        arith_invalid,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [79:0] result
);

    poly_state_t state;
    logic [3:0]  sel_q;
    logic [3:0]  index;
    logic [79:0] x_q;
    logic [79:0] acc;

    assign rom_poly_select = sel_q;
    assign rom_coeff_index = index;

    // Each request is registered on entry to its *_REQ state so arith_req is
    // high exactly during that state and the operands stay put until done.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            sel_q     <= '0;
            x_q       <= '0;
            acc       <= '0;
            index     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            result    <= '0;
            arith_req <= 1'b0;
            arith_op  <= OP_MUL;
            arith_a   <= '0;
            arith_b   <= '0;
        end else begin
            done      <= 1'b0;
            arith_req <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sel_q <= poly_select;
                        x_q   <= x_in;
                        busy  <= 1'b1;
                        if (poly_select > POLY_LOG2) begin
                            acc   <= '0;
                            error <= 1'b1;
                            state <= DONE;
                        end else begin
                            error <= 1'b0;
                            index <= coeff_count(poly_select) - 4'd1;
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    acc       <= rom_coefficient;
                    index     <= index - 4'd1;
                    arith_req <= 1'b1;
                    arith_op  <= OP_MUL;
                    arith_a   <= rom_coefficient;
                    arith_b   <= x_q;
                    state     <= MUL_REQ;
                end
                MUL_REQ: state <= MUL_WAIT;
                ADD_REQ: state <= ADD_WAIT;
                FIN_REQ: state <= FIN_WAIT;
                MUL_WAIT: begin
                    if (arith_done) begin
                        if (arith_invalid) begin
                            acc   <= FP80_DEFAULT_QNAN;
                            error <= 1'b1;
                            state <= DONE;
                        end else begin
                            acc       <= arith_result;
                            arith_req <= 1'b1;
                            arith_op  <= OP_ADD;
                            arith_a   <= arith_result;
                            arith_b   <= rom_coefficient;
                            state     <= ADD_REQ;
                        end
                    end
                end
                ADD_WAIT: begin
                    if (arith_done) begin
                        if (arith_invalid) begin
                            acc   <= FP80_DEFAULT_QNAN;
                            error <= 1'b1;
                            state <= DONE;
                        end else begin
                            acc       <= arith_result;
                            arith_req <= 1'b1;
                            arith_op  <= OP_MUL;
                            arith_a   <= arith_result;
                            arith_b   <= x_q;
                            if (index != 4'd0) begin
                                index <= index - 4'd1;
                                state <= MUL_REQ;
                            end else begin
                                state <= FIN_REQ;
                            end
                        end
                    end
                end
                FIN_WAIT: begin
                    if (arith_done) begin
                        if (arith_invalid) begin
                            acc   <= FP80_DEFAULT_QNAN;
                            error <= 1'b1;
                        end else begin
                            acc <= arith_result;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    result <= acc;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
